regfile_scoreboard: RTL and testbench

- Tracks in-flight writes to the 32-entry general register file so that the issue stage can detect RAW hazards on source operands.
- Sits between the decode/issue stage and writeback. Issue marks a destination pending; writeback retires it.
- Per-register counters allow several in-flight writes to the same register.
- Exception or branch-mispredict flush clears all pending state.

---
 rtl/regfile_scoreboard.sv | 120 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//
// Tracks in-flight writes to the 32-entry register file so the issue stage
// can detect RAW hazards. Each register has a small pending-write counter:
// issue increments it, writeback decrements it, and flush clears all of them.
//
// Handshake: an issue transfers in a cycle where issue_valid and issue_ready
// are both high. issue_ready never looks at issue_valid. It may depend on
// issue_dest, wb_valid and wb_dest in the same cycle. Writeback has no
// back-pressure: a wb_valid pulse always retires one write.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   issue_valid/dest   instruction writing issue_dest wants to issue
//   issue_ready        scoreboard can take that issue this cycle
//   wb_valid/dest      one write to wb_dest retires
//   flush              discard all pending writes
//   src1/2_addr        source operand indices to look up
//   src1/2_busy        source operand has a pending write
//   busy_vec           bit i = register i has a pending write (bit 0 always 0)
//   wb_underflow       sticky: a writeback hit a register with no pending write
//
// Optional build macro: SCOREBOARD_FWD_EN. When it is defined, srcN_busy
// drops in the same cycle that the last pending write to srcN_addr retires,
// because the datapath forwards the writeback value.
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int CNT_W     = 2,
    parameter int NREG_LOG2 = 5
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 issue_valid,
    input  logic [NREG_LOG2-1:0] issue_dest,
    output logic                 issue_ready,
    input  logic                 wb_valid,
    input  logic [NREG_LOG2-1:0] wb_dest,
    input  logic                 flush,
    input  logic [NREG_LOG2-1:0] src1_addr,
    input  logic [NREG_LOG2-1:0] src2_addr,
    output logic                 src1_busy,
    output logic                 src2_busy,
    output logic [31:0]          busy_vec,
    output logic                 wb_underflow
);

    localparam int NREG = 1 << NREG_LOG2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt [NREG];
    logic [NREG-1:0]  issue_hot;
    logic [NREG-1:0]  wb_hot;
    logic             issue_fire;
    logic             wb_same_as_issue;
    logic             underflow_now;

    // A full counter can still accept an issue if the same register retires
    // in this cycle: the two cancel and the count stays at its maximum.
    assign wb_same_as_issue = wb_valid && (wb_dest == issue_dest);
    assign issue_ready = !((cnt[issue_dest] == CNT_MAX) && !wb_same_as_issue);
    assign issue_fire  = issue_valid && issue_ready;

    // One-hot decode. Register 0 is masked out so it is never tracked.
    always_comb begin
        issue_hot = '0;
        wb_hot    = '0;
        if (issue_fire) issue_hot[issue_dest] = 1'b1;
        if (wb_valid)   wb_hot[wb_dest]       = 1'b1;
        issue_hot[0] = 1'b0;
        wb_hot[0]    = 1'b0;
    end

    // An underflow is a retire to a tracked register with a zero count that
    // is not paired with an issue to the same register. That pairing is a
    // legal bypass.
    assign underflow_now = !flush && wb_valid && (wb_dest != '0) &&
                           (cnt[wb_dest] == '0) &&
                           !(issue_fire && wb_same_as_issue);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) cnt[i] <= '0;
            wb_underflow <= 1'b0;
        end else begin
            if (underflow_now) wb_underflow <= 1'b1;
            cnt[0] <= '0;
            for (int i = 1; i < NREG; i++) begin
                if (flush) begin
                    cnt[i] <= '0;
                end else begin
                    case ({issue_hot[i], wb_hot[i]})
                        2'b10:   cnt[i] <= cnt[i] + CNT_ONE;
                        2'b01:   if (cnt[i] != '0) cnt[i] <= cnt[i] - CNT_ONE;
                        default: cnt[i] <= cnt[i];
                    endcase
                end
            end
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int i = 1; i < NREG; i++) busy_vec[i] = (cnt[i] != '0);
    end

`ifdef SCOREBOARD_FWD_EN
    // The last pending write retiring this cycle is forwarded, so the
    // consumer does not have to wait for the counter to clear.
    assign src1_busy = busy_vec[src1_addr] &&
                       !(wb_valid && (wb_dest == src1_addr) && (cnt[src1_addr] == CNT_ONE));
    assign src2_busy = busy_vec[src2_addr] &&
                       !(wb_valid && (wb_dest == src2_addr) && (cnt[src2_addr] == CNT_ONE));
`else
    assign src1_busy = busy_vec[src1_addr];
    assign src2_busy = busy_vec[src2_addr];
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_regfile_scoreboard
//
// Directed and random stimulus for regfile_scoreboard. A reference model
// holds one integer pending count per register and applies the issue,
// retire and flush rules with plain arithmetic. Outputs are sampled 1 ns
// after the inputs change, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_regfile_scoreboard;

    logic        clk;
    logic        resetn;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic        issue_ready;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic        flush;
    logic [4:0]  src1_addr;
    logic [4:0]  src2_addr;
    logic        src1_busy;
    logic        src2_busy;
    logic [31:0] busy_vec;
    logic        wb_underflow;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int model_cnt [32];
    bit model_uf;

    localparam int MAXCNT = 3;

    regfile_scoreboard #(.CNT_W(2), .NREG_LOG2(5)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .issue_valid  (issue_valid),
        .issue_dest   (issue_dest),
        .issue_ready  (issue_ready),
        .wb_valid     (wb_valid),
        .wb_dest      (wb_dest),
        .flush        (flush),
        .src1_addr    (src1_addr),
        .src2_addr    (src2_addr),
        .src1_busy    (src1_busy),
        .src2_busy    (src2_busy),
        .busy_vec     (busy_vec),
        .wb_underflow (wb_underflow)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_cnt[i] = 0;
        model_uf = 1'b0;
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] v;
        v = '0;
        for (int i = 1; i < 32; i++) v[i] = (model_cnt[i] > 0);
        return v;
    endfunction

    function automatic bit model_ready(input int d, input bit wv, input int wd);
        return !(model_cnt[d] == MAXCNT && !(wv && wd == d));
    endfunction

    function automatic bit model_src_busy(input int s, input bit wv, input int wd);
        bit b;
        b = (s != 0) && (model_cnt[s] > 0);
`ifdef SCOREBOARD_FWD_EN
        if (wv && wd == s && model_cnt[s] == 1) b = 1'b0;
`endif
        return b;
    endfunction

    // Apply one clock edge to the model.
    task automatic model_step(input bit iv, input int id, input bit wv, input int wd, input bit fl);
        bit fire;
        fire = iv && model_ready(id, wv, wd);
        if (fl) begin
            for (int i = 0; i < 32; i++) model_cnt[i] = 0;
        end else if (fire && wv && id == wd) begin
            // Issue and retire to the same register cancel out.
        end else begin
            if (fire && id != 0) model_cnt[id] = model_cnt[id] + 1;
            if (wv && wd != 0) begin
                if (model_cnt[wd] > 0) model_cnt[wd] = model_cnt[wd] - 1;
                else model_uf = 1'b1;
            end
        end
    endtask

    // Driver: present one cycle of inputs, check outputs, clock, update model.
    task automatic cycle(input bit iv, input int id, input bit wv, input int wd,
                         input bit fl, input int s1, input int s2);
        issue_valid = iv;
        issue_dest  = 5'(id);
        wb_valid    = wv;
        wb_dest     = 5'(wd);
        flush       = fl;
        src1_addr   = 5'(s1);
        src2_addr   = 5'(s2);
        #1;
        check("issue_ready", {31'b0, issue_ready}, {31'b0, model_ready(id, wv, wd)});
        check("busy_vec", busy_vec, model_busy());
        check("src1_busy", {31'b0, src1_busy}, {31'b0, model_src_busy(s1, wv, wd)});
        check("src2_busy", {31'b0, src2_busy}, {31'b0, model_src_busy(s2, wv, wd)});
        check("wb_underflow", {31'b0, wb_underflow}, {31'b0, model_uf});
        @(posedge clk);
        model_step(iv, id, wv, wd, fl);
        #1;
    endtask

    task automatic idle(input int s1, input int s2);
        cycle(0, 0, 0, 0, 0, s1, s2);
    endtask

    initial begin
        model_reset();
        resetn      = 1'b0;
        issue_valid = 1'b0;
        issue_dest  = '0;
        wb_valid    = 1'b0;
        wb_dest     = '0;
        flush       = 1'b0;
        src1_addr   = '0;
        src2_addr   = '0;
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        @(posedge clk);
        #1;

        // Reset state.
        check("rst_busy_vec", busy_vec, 32'h0);
        check("rst_issue_ready", {31'b0, issue_ready}, 32'h1);
        check("rst_underflow", {31'b0, wb_underflow}, 32'h0);
        idle(1, 2);

        // Single issue then retire on r5.
        cycle(1, 5, 0, 0, 0, 5, 0);
        #1;
        check("iss5_busy_vec", busy_vec, 32'h0000_0020);
        check("iss5_src1", {31'b0, src1_busy}, 32'h1);
        cycle(0, 0, 1, 5, 0, 5, 5);
        check("wb5_busy_vec", busy_vec, 32'h0);
        idle(5, 0);

        // Fill r7 to its maximum count.
        repeat (3) cycle(1, 7, 0, 0, 0, 7, 0);
        issue_valid = 1'b1; issue_dest = 5'd7; wb_valid = 1'b0;
        #1;
        check("full_not_ready", {31'b0, issue_ready}, 32'h0);
        cycle(1, 7, 0, 0, 0, 7, 0);
        wb_valid = 1'b1; wb_dest = 5'd7;
        #1;
        check("full_wb_ready", {31'b0, issue_ready}, 32'h1);
        cycle(1, 7, 1, 7, 0, 7, 0);
        check("full_stays", {30'b0, 2'(model_cnt[7])}, 32'd3);
        repeat (3) cycle(0, 0, 1, 7, 0, 7, 0);
        idle(7, 0);
        check("r7_drained", busy_vec, 32'h0);

        // Register 0 is never tracked.
        cycle(1, 0, 0, 0, 0, 0, 0);
        idle(0, 0);
        cycle(0, 0, 1, 0, 0, 0, 0);
        idle(0, 0);
        check("r0_no_uf", {31'b0, wb_underflow}, 32'h0);

        // Issue and retire to an idle register in the same cycle: bypass.
        cycle(1, 11, 1, 11, 0, 11, 0);
        idle(11, 0);

        // Flush discards pending writes and the same-cycle issue.
        cycle(1, 3, 0, 0, 0, 3, 9);
        cycle(1, 9, 0, 0, 0, 3, 9);
        cycle(1, 31, 0, 0, 0, 31, 9);
        check("pre_flush", busy_vec, 32'h8000_0208);
        cycle(1, 12, 0, 0, 1, 12, 31);
        check("post_flush", busy_vec, 32'h0);
        idle(12, 3);

        // Underflow is sticky across flush.
        cycle(0, 0, 1, 4, 0, 4, 0);
        check("uf_set", {31'b0, wb_underflow}, 32'h1);
        cycle(0, 0, 0, 0, 1, 4, 0);
        check("uf_after_flush", {31'b0, wb_underflow}, 32'h1);

        // Random traffic with a small register range to force hazards.
        for (int n = 0; n < 400; n++) begin
            int id, wd;
            bit iv, wv, fl;
            id = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5));
            wd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5));
            iv = ($urandom_range(0, 99) < 60);
            wv = ($urandom_range(0, 99) < 45);
            fl = ($urandom_range(0, 99) < 3);
            cycle(iv, id, wv, wd, fl, int'($urandom_range(0, 7)), int'($urandom_range(0, 31)));
            if (n == 200) begin
                // Asynchronous reset in the middle of a cycle.
                cycle(1, 2, 0, 0, 0, 2, 3);
                cycle(1, 3, 0, 0, 0, 2, 3);
                #2 resetn = 1'b0;
                #1;
                model_reset();
                check("async_rst_busy", busy_vec, 32'h0);
                check("async_rst_ready", {31'b0, issue_ready}, 32'h1);
                check("async_rst_uf", {31'b0, wb_underflow}, 32'h0);
                check("async_rst_src", {30'b0, src1_busy, src2_busy}, 32'h0);
                @(posedge clk);
                #1 resetn = 1'b1;
            end
        end

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
